// File: rtl/stream_window_kernel.sv
`default_nettype none
// ============================================================================
// Module   : stream_window_kernel
// Function : Column-fed sliding window with line-aware fill, stride and
//            output backpressure (HOG front end).
// Revision : 1.0
// ============================================================================
module stream_window_kernel #(
    parameter int BLOCK_WIDTH  = 3,
    parameter int BLOCK_HEIGHT = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int STRIDE       = 1,
    parameter int IMG_WIDTH    = 640,
    parameter int COL_WIDTH    = $clog2(IMG_WIDTH),
    parameter int INPUT_WIDTH  = DATA_WIDTH * BLOCK_HEIGHT,
    parameter int OUTPUT_WIDTH = BLOCK_WIDTH * BLOCK_HEIGHT * DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [INPUT_WIDTH-1:0]  in_pixels,
    input  logic                    in_valid,
    input  logic                    in_sol,
    output logic                    in_ready,
    output logic [OUTPUT_WIDTH-1:0] out_pixels,
    output logic [COL_WIDTH-1:0]    out_x,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [COL_WIDTH-1:0] c_COL_LAST  = COL_WIDTH'(IMG_WIDTH - 1);
    localparam logic [COL_WIDTH-1:0] c_FILL_LAST = COL_WIDTH'(BLOCK_WIDTH - 1);
    localparam logic [SW-1:0]        c_STR_LAST  = SW'(STRIDE - 1);

    logic [DATA_WIDTH-1:0] r_win [BLOCK_HEIGHT][BLOCK_WIDTH];
    logic [COL_WIDTH-1:0]  r_col_cnt;
    logic [SW-1:0]         r_stride_cnt;
    logic [COL_WIDTH-1:0]  r_out_x;
    logic                  r_out_valid;

    logic                  w_accept;
    logic [COL_WIDTH-1:0]  w_e;
    logic                  w_fill;
    logic                  w_emit;
    logic                  w_eol;

    // Window may only advance once the held window has been taken.
    assign in_ready  = ~r_out_valid | out_ready;
    assign w_accept  = in_valid & in_ready;
    assign w_e       = in_sol ? '0 : r_col_cnt;
    assign w_fill    = (w_e < c_FILL_LAST);
    assign w_emit    = ~w_fill & (r_stride_cnt == '0);
    assign w_eol     = (w_e == c_COL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < BLOCK_HEIGHT; r++) begin
                for (int c = 0; c < BLOCK_WIDTH; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < BLOCK_HEIGHT; r++) begin
                for (int c = 0; c < BLOCK_WIDTH - 1; c++) begin
                    r_win[r][c] <= r_win[r][c+1];
                end
                r_win[r][BLOCK_WIDTH-1] <= in_pixels[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col_cnt    <= '0;
            r_stride_cnt <= '0;
            r_out_x      <= '0;
            r_out_valid  <= 1'b0;
        end else if (w_accept) begin
            r_col_cnt <= w_eol ? '0 : w_e + COL_WIDTH'(1);
            // A wrapping column closes the line, so stride phase restarts.
            if (w_fill || w_eol) begin
                r_stride_cnt <= '0;
            end else begin
                r_stride_cnt <= (r_stride_cnt == c_STR_LAST) ? '0 : r_stride_cnt + SW'(1);
            end
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_x <= w_e - c_FILL_LAST;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    for (genvar r = 0; r < BLOCK_HEIGHT; r++) begin : g_row
        for (genvar c = 0; c < BLOCK_WIDTH; c++) begin : g_col
            assign out_pixels[(r*BLOCK_WIDTH + c)*DATA_WIDTH +: DATA_WIDTH] = r_win[r][c];
        end
    end

    assign out_x     = r_out_x;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_window_kernel.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_window_kernel
// Function : Directed bench for stream_window_kernel (8-pixel lines, 3x3).
// Revision : 1.0
// ============================================================================
module tb_stream_window_kernel;

    localparam int BW = 3;
    localparam int BH = 3;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int CW = 3;
    localparam int INW  = BW * 0 + DW * BH;
    localparam int OUTW = BW * BH * DW;

    logic            clk;
    logic            rst;
    logic [INW-1:0]  in_pixels,  in2_pixels;
    logic            in_valid,   in2_valid;
    logic            in_sol,     in2_sol;
    logic            in_ready,   in2_ready;
    logic [OUTW-1:0] out_pixels, out2_pixels;
    logic [CW-1:0]   out_x,      out2_x;
    logic            out_valid,  out2_valid;
    logic            out_ready,  out2_ready;

    int vectors;
    int miscompares;
    int windows;

    stream_window_kernel #(
        .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .DATA_WIDTH(DW),
        .STRIDE(1), .IMG_WIDTH(IW)
    ) u_dut_s1 (
        .clk(clk), .rst(rst),
        .in_pixels(in_pixels), .in_valid(in_valid), .in_sol(in_sol), .in_ready(in_ready),
        .out_pixels(out_pixels), .out_x(out_x), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_window_kernel #(
        .BLOCK_WIDTH(BW), .BLOCK_HEIGHT(BH), .DATA_WIDTH(DW),
        .STRIDE(2), .IMG_WIDTH(IW)
    ) u_dut_s2 (
        .clk(clk), .rst(rst),
        .in_pixels(in2_pixels), .in_valid(in2_valid), .in_sol(in2_sol), .in_ready(in2_ready),
        .out_pixels(out2_pixels), .out_x(out2_x), .out_valid(out2_valid), .out_ready(out2_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [OUTW-1:0] obs, input logic [OUTW-1:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Column whose row r pixel is 16*r + v.
    function automatic logic [INW-1:0] col(input int v);
        logic [INW-1:0] p;
        for (int r = 0; r < BH; r++) p[r*DW +: DW] = DW'(16*r + v);
        return p;
    endfunction

    // Window whose leftmost column has value base.
    function automatic logic [OUTW-1:0] win(input int base);
        logic [OUTW-1:0] w;
        for (int r = 0; r < BH; r++)
            for (int c = 0; c < BW; c++)
                w[(r*BW + c)*DW +: DW] = DW'(16*r + base + c);
        return w;
    endfunction

    task automatic push(input int v, input bit sol);
        in_pixels = col(v);
        in_sol    = sol;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_sol    = 1'b0;
    endtask

    task automatic push2(input int v, input bit sol);
        in2_pixels = col(v);
        in2_sol    = sol;
        in2_valid  = 1'b1;
        @(posedge clk);
        #1;
        in2_valid  = 1'b0;
        in2_sol    = 1'b0;
    endtask

    // Pushes one column on dut1 and checks the window expected one cycle later.
    task automatic push_chk(input int v, input bit sol, input bit exp_valid, input int exp_x, input int exp_base);
        push(v, sol);
        check("valid", OUTW'(out_valid), OUTW'(exp_valid));
        if (exp_valid) begin
            windows++;
            check("out_x", OUTW'(out_x), OUTW'(exp_x));
            check("window", out_pixels, win(exp_base));
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; windows = 0;
        rst = 1'b0;
        in_pixels = '0; in_valid = 1'b0; in_sol = 1'b0; out_ready = 1'b1;
        in2_pixels = '0; in2_valid = 1'b0; in2_sol = 1'b0; out2_ready = 1'b1;
        #22;
        check("rst_valid",  OUTW'(out_valid), '0);
        check("rst_x",      OUTW'(out_x), '0);
        check("rst_pixels", out_pixels, '0);
        check("rst_ready",  OUTW'(in_ready), OUTW'(1));
        rst = 1'b1;
        @(posedge clk); #1;

        // Fill, latency and two back-to-back lines without a second sol.
        for (int l = 0; l < 2; l++) begin
            for (int x = 0; x < IW; x++) begin
                push_chk(x, (l == 0 && x == 0), (x >= BW-1), x - (BW-1), x - (BW-1));
                if (l == 0 && x == 2) begin
                    check("row0", OUTW'(out_pixels[23:0]),  OUTW'(24'h020100));
                    check("row2", OUTW'(out_pixels[71:48]), OUTW'(24'h222120));
                end
            end
        end
        check("windows", OUTW'(windows), OUTW'(12));
        @(posedge clk); #1;
        check("idle_clear", OUTW'(out_valid), '0);

        // Stride 2.
        windows = 0;
        for (int x = 0; x < IW; x++) begin
            push2(x, x == 0);
            if (x >= 2 && (x % 2) == 0) begin
                windows++;
                check("s2_valid", OUTW'(out2_valid), OUTW'(1));
                check("s2_x", OUTW'(out2_x), OUTW'(x - 2));
                check("s2_window", out2_pixels, win(x - 2));
            end else begin
                check("s2_idle", OUTW'(out2_valid), '0);
            end
        end
        check("s2_windows", OUTW'(windows), OUTW'(3));

        // Backpressure.
        push_chk(0, 1'b1, 1'b0, 0, 0);
        push_chk(1, 1'b0, 1'b0, 0, 0);
        push_chk(2, 1'b0, 1'b1, 0, 0);
        out_ready = 1'b0;
        in_pixels = col(3);
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_ready", OUTW'(in_ready), '0);
            check("bp_valid", OUTW'(out_valid), OUTW'(1));
            check("bp_x", OUTW'(out_x), '0);
            check("bp_window", out_pixels, win(0));
        end
        out_ready = 1'b1;
        push_chk(3, 1'b0, 1'b1, 1, 1);
        push_chk(4, 1'b0, 1'b1, 2, 2);

        // Resync with sol mid-line; post-sol pixels use base 100.
        push_chk(0, 1'b1, 1'b0, 0, 0);
        push_chk(1, 1'b0, 1'b0, 0, 0);
        push_chk(2, 1'b0, 1'b1, 0, 0);
        push_chk(3, 1'b0, 1'b1, 1, 1);
        push_chk(100, 1'b1, 1'b0, 0, 0);
        push_chk(101, 1'b0, 1'b0, 0, 0);
        push_chk(102, 1'b0, 1'b1, 0, 100);

        // Asynchronous reset while a window is stalled.
        push_chk(0, 1'b1, 1'b0, 0, 0);
        push_chk(1, 1'b0, 1'b0, 0, 0);
        push_chk(2, 1'b0, 1'b1, 0, 0);
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("arst_valid", OUTW'(out_valid), '0);
        check("arst_ready", OUTW'(in_ready), OUTW'(1));
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", OUTW'(in_ready), OUTW'(1));
        push_chk(50, 1'b0, 1'b0, 0, 0);
        push_chk(51, 1'b0, 1'b0, 0, 0);
        push_chk(52, 1'b0, 1'b1, 0, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_window_kernel.md
Name: stream_window_kernel

Overview:
- Parametrised sliding-window generator for the HOG front end.
- Accepts one column of BLOCK_HEIGHT vertically aligned pixels per transfer, taken from the line buffers, over a single valid/ready handshake.
- Emits a full BLOCK_WIDTH x BLOCK_HEIGHT window with its horizontal position.
- Adds line-aware fill, configurable horizontal stride and output backpressure on top of the per-row shift-register kernel; feeds gradient/cell stages.

Parameters:
- BLOCK_WIDTH, 3, window columns (2..IMG_WIDTH).
- BLOCK_HEIGHT, 3, window rows (>=1).
- DATA_WIDTH, 8, bits per pixel.
- STRIDE, 1, horizontal step between emitted windows (>=1).
- IMG_WIDTH, 640, pixels per image line.
- COL_WIDTH, $clog2(IMG_WIDTH), column counter/index width.
- INPUT_WIDTH, DATA_WIDTH*BLOCK_HEIGHT, column bus width.
- OUTPUT_WIDTH, BLOCK_WIDTH*BLOCK_HEIGHT*DATA_WIDTH, window bus width.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_pixels  input  INPUT_WIDTH  column; row r at [r*DATA_WIDTH +: DATA_WIDTH], r=0 top.
- in_valid  input  1  column valid.
- in_sol  input  1  start-of-line marker, qualified by in_valid.
- in_ready  output  1  column accepted when in_valid & in_ready.
- out_pixels  output  OUTPUT_WIDTH  window; row r at [r*BLOCK_WIDTH*DATA_WIDTH +: BLOCK_WIDTH*DATA_WIDTH]; within a row, column c at [c*DATA_WIDTH +: DATA_WIDTH], c=0 oldest/leftmost.
- out_x  output  COL_WIDTH  image column of window's leftmost pixel.
- out_valid  output  1  window valid.
- out_ready  input  1  downstream accepts window.

Behaviour:
- Reset (rst=0, async):
  - window registers, col_cnt, stride_cnt, out_x and out_valid are 0.
  - in_ready is 1 after reset (combinational).
- in_ready = ~out_valid | out_ready.
  - No internal skid.
  - Window registers must not shift while an unconsumed window is held.
- Accept (in_valid & in_ready):
  - every row shifts left one column; the new pixel enters column BLOCK_WIDTH-1.
  - effective column index e = 0 if in_sol=1, else col_cnt.
  - col_cnt <= (e == IMG_WIDTH-1) ? 0 : e+1.
- Emit rule, evaluated on the accepted column with index e:
  - fill: e < BLOCK_WIDTH-1 -> no emit; stride_cnt <= 0.
  - e >= BLOCK_WIDTH-1 and stride_cnt == 0 -> emit.
  - stride_cnt <= (stride_cnt == STRIDE-1) ? 0 : stride_cnt+1 for every accept with e >= BLOCK_WIDTH-1.
  - line wrap (e == IMG_WIDTH-1) or in_sol -> stride_cnt restarts at 0 for the next line. Windows never span two lines.
- Emit:
  - out_valid <= 1 and out_x <= e-(BLOCK_WIDTH-1).
  - Window is visible the cycle after the accepting edge (latency 1).
- Otherwise, if out_ready, out_valid <= 0.
- Accept and out_ready high in the same cycle:
  - old window consumed; new shift occurs.
  - out_valid reflects the new emit decision, giving full throughput of 1 column/cycle.
- Stall (out_valid & ~out_ready): out_pixels, out_x and out_valid stay stable; in_ready=0.
- in_valid low: no state change except out_valid clearing on out_ready.
- in_sol mid-line: the current line is abandoned and fill restarts. Stale columns in the registers are never emitted because fill suppresses output.
- Reset mid-stream: the pending window is dropped; the next accepted column is treated as column 0.
- Counters wrap exactly at IMG_WIDTH-1, with no overflow beyond COL_WIDTH bits.

Test Plan:
- Fill/latency, BW=BH=3, IMG_WIDTH=8, STRIDE=1:
  - stimulus: columns with row r pixel = 16*r+x, x=0..7, out_ready=1.
  - required: 6 windows, out_x=0..5, each one cycle after its column; first window row0 = {0,1,2} (c=0..2), row2 = {32,33,34}.
- Stride:
  - stimulus: same stream with STRIDE=2.
  - required: windows at out_x=0,2,4 only; 3 windows per line.
- Backpressure:
  - stimulus: out_ready held low 4 cycles after the first window.
  - required: in_ready=0 and out_pixels/out_x=0 held; after release, out_x=1 next with no column lost or duplicated.
- Line wrap:
  - stimulus: 2 lines back-to-back without in_sol.
  - required: no window with x spanning the line boundary; second line emits out_x=0..5 again; 12 windows total.
- Resync:
  - stimulus: in_sol asserted at column 4 of a line.
  - required: no emit for that column or the next one; next window has out_x=0 and contains only post-sol pixels.
- Async reset:
  - stimulus: rst=0 asserted mid-window while out_valid=1 and out_ready=0.
  - required: out_valid=0 immediately without a clock edge; after release, in_ready=1 and the next stream starts at out_x=0.
